// File: rtl/sync_fifo_pkg.sv
// Shared types, reset values and sizing helper for the parametrised sync FIFO.
package sync_fifo_pkg;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_status_t;

  localparam fifo_status_t STATUS_RST = '{
    full:         1'b0,
    empty:        1'b1,
    almost_full:  1'b0,
    almost_empty: 1'b1
  };

  localparam logic RST_RD_VALID = 1'b0;
  localparam logic RST_ERR      = 1'b0;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_ram_2p.sv
// Simple dual-port RAM, read-first, with a registered read port that resets to zero.
module fifo_ram_2p
  import sync_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW = ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Non-blocking update gives read-first behaviour on a same-address write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with registered flags and sticky error flags.
// Define SYNC_FIFO_PARITY_EN to store and check even parity per word.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned AFULL_LVL  = DEPTH - 2,
  parameter int unsigned AEMPTY_LVL = 2,
  localparam int unsigned PW = ptr_w(DEPTH),
  localparam int unsigned CW = PW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow,
  input  logic              err_clr,
  output logic              parity_err
);

`ifdef SYNC_FIFO_PARITY_EN
  localparam int unsigned RAM_W = DATA_W + 1;
`else
  localparam int unsigned RAM_W = DATA_W;
`endif

  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  fifo_status_t   status_q, status_d;
  logic           rd_valid_q;
  logic           overflow_q, overflow_d;
  logic           underflow_q, underflow_d;
  logic           wr_acc, rd_acc;
  logic [RAM_W-1:0] ram_wdata, ram_rdata;

  // A read at full frees the slot the write lands in; no bypass at empty.
  assign wr_acc = wr_en & (~status_q.full | rd_en);
  assign rd_acc = rd_en & ~status_q.empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + PW'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + PW'(1);
    if (wr_acc && !rd_acc) begin
      count_d = count_q + CW'(1);
    end else if (rd_acc && !wr_acc) begin
      count_d = count_q - CW'(1);
    end
  end

  always_comb begin
    status_d              = STATUS_RST;
    status_d.full         = (count_d == CW'(DEPTH));
    status_d.empty        = (count_d == '0);
    status_d.almost_full  = (count_d >= CW'(AFULL_LVL));
    status_d.almost_empty = (count_d <= CW'(AEMPTY_LVL));
  end

  // Setting wins over err_clr in the same cycle.
  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (err_clr) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (wr_en && !wr_acc)        overflow_d  = 1'b1;
    if (rd_en && status_q.empty) underflow_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      status_q    <= STATUS_RST;
      rd_valid_q  <= RST_RD_VALID;
      overflow_q  <= RST_ERR;
      underflow_q <= RST_ERR;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      status_q    <= status_d;
      rd_valid_q  <= rd_acc;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_ram_2p #(
    .WIDTH (RAM_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc),
    .waddr (wr_ptr_q),
    .wdata (ram_wdata),
    .re    (rd_acc),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata)
  );

`ifdef SYNC_FIFO_PARITY_EN
  assign ram_wdata  = {^wr_data, wr_data};
  assign rd_data    = ram_rdata[DATA_W-1:0];
  // Stored bit makes the word even, so any odd total is a corrupted word.
  assign parity_err = rd_valid_q & (^ram_rdata);
`else
  assign ram_wdata  = wr_data;
  assign rd_data    = ram_rdata;
  assign parity_err = 1'b0;
`endif

  assign rd_valid     = rd_valid_q;
  assign count        = count_q;
  assign full         = status_q.full;
  assign empty        = status_q.empty;
  assign almost_full  = status_q.almost_full;
  assign almost_empty = status_q.almost_empty;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param (DEPTH 8, DATA_W 8) with a queue model for the random phase.
module tb_sync_fifo_param;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       rd_en = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [3:0] count;
  logic       full, empty, almost_full, almost_empty;
  logic       overflow, underflow, parity_err;

  int checks = 0;
  int errors = 0;

  sync_fifo_param #(
    .DATA_W     (8),
    .DEPTH      (8),
    .AFULL_LVL  (6),
    .AEMPTY_LVL (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow),
    .err_clr      (err_clr),
    .parity_err   (parity_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] q[$];
  logic [7:0] exp_data;
  bit         w, r, wacc, racc;

  initial begin
    // Reset values
    #1 rst = 1'b1;
    #1;
    check("rst_count", 32'(count), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_aempty", 32'(almost_empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_afull", 32'(almost_full), 0);
    check("rst_rd_data", 32'(rd_data), 0);
    check("rst_rd_valid", 32'(rd_valid), 0);
    check("rst_errs", 32'({overflow, underflow, parity_err}), 0);
    step();
    rst = 1'b0;

    // 1 Fill
    for (int i = 1; i <= 8; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      step();
      check("fill_count", 32'(count), 32'(i));
      check("fill_afull", 32'(almost_full), (i >= 6) ? 1 : 0);
      check("fill_full", 32'(full), (i == 8) ? 1 : 0);
      check("fill_aempty", 32'(almost_empty), (i <= 2) ? 1 : 0);
    end

    // 2 Overflow and drain
    wr_data = 8'hAA;
    step();
    check("ovf_flag", 32'(overflow), 1);
    check("ovf_count", 32'(count), 8);
    wr_en = 1'b0; rd_en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      check("drain_valid", 32'(rd_valid), 1);
      check("drain_data", 32'(rd_data), 32'(i));
      check("drain_parity", 32'(parity_err), 0);
    end
    check("drain_empty", 32'(empty), 1);
    check("drain_count", 32'(count), 0);
    rd_en = 1'b0; err_clr = 1'b1;
    step();
    check("ovf_clr", 32'(overflow), 0);
    err_clr = 1'b0;

    // 3 Underflow
    rd_en = 1'b1;
    step();
    check("udf_flag", 32'(underflow), 1);
    check("udf_valid", 32'(rd_valid), 0);
    check("udf_data", 32'(rd_data), 8);
    err_clr = 1'b1;
    step();
    check("udf_set_over_clr", 32'(underflow), 1);
    rd_en = 1'b0;
    step();
    check("udf_clr", 32'(underflow), 0);
    err_clr = 1'b0;

    // 4 Simultaneous at full and at empty
    wr_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wr_data = 8'(8'h10 + i);
      step();
    end
    check("sim_full", 32'(full), 1);
    rd_en = 1'b1; wr_data = 8'h55;
    step();
    check("sim_full_count", 32'(count), 8);
    check("sim_full_valid", 32'(rd_valid), 1);
    check("sim_full_data", 32'(rd_data), 32'h10);
    check("sim_full_ovf", 32'(overflow), 0);
    wr_en = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step();
      check("sim_drain", 32'(rd_data), (i == 8) ? 32'h55 : 32'(8'h10 + i));
    end
    check("sim_drain_empty", 32'(empty), 1);
    wr_en = 1'b1; wr_data = 8'h33;
    step();
    check("sim_empty_count", 32'(count), 1);
    check("sim_empty_valid", 32'(rd_valid), 0);
    check("sim_empty_data", 32'(rd_data), 32'h55);
    wr_en = 1'b0;
    step();
    check("sim_empty_read", 32'(rd_data), 32'h33);
    check("sim_empty_rvalid", 32'(rd_valid), 1);
    rd_en = 1'b0; err_clr = 1'b1;
    step();
    err_clr = 1'b0;

    // 5 Random interleave against a queue model
    for (int n = 0; n < 24; n++) begin
      w = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      wr_en = w; rd_en = r; wr_data = 8'($urandom_range(0, 255));
      wacc = w && (q.size() < 8 || r);
      racc = r && (q.size() > 0);
      if (racc) exp_data = q.pop_front();
      if (wacc) q.push_back(wr_data);
      step();
      check("rnd_count", 32'(count), 32'(q.size()));
      check("rnd_valid", 32'(rd_valid), racc ? 1 : 0);
      if (racc) check("rnd_data", 32'(rd_data), 32'(exp_data));
      check("rnd_flags", 32'({full, empty, almost_full, almost_empty}),
            32'({q.size() == 8, q.size() == 0, q.size() >= 6, q.size() <= 2}));
    end
    wr_en = 1'b0; rd_en = 1'b0;
    for (int n = 0; n < 16 && q.size() != 5; n++) begin
      if (q.size() < 5) begin
        wr_en = 1'b1; rd_en = 1'b0; wr_data = 8'(n);
        q.push_back(wr_data);
      end else begin
        wr_en = 1'b0; rd_en = 1'b1;
        exp_data = q.pop_front();
      end
      step();
    end
    wr_en = 1'b0; rd_en = 1'b0;
    step();
    check("pre_rst_count", 32'(count), 5);
    #3 rst = 1'b1;
    #1;
    check("mid_rst_count", 32'(count), 0);
    check("mid_rst_empty", 32'(empty), 1);
    check("mid_rst_rd", 32'({rd_valid, rd_data}), 0);
    #1 rst = 1'b0;
    q.delete();
    wr_en = 1'b1; wr_data = 8'h77;
    step();
    wr_en = 1'b0; rd_en = 1'b1;
    step();
    check("post_rst_data", 32'(rd_data), 32'h77);
    check("post_rst_count", 32'(count), 0);
    rd_en = 1'b0;

    // 6 Parity
    wr_en = 1'b1; wr_data = 8'h0F;
    step();
    wr_en = 1'b0;
`ifdef SYNC_FIFO_PARITY_EN
    begin
      logic [8:0] word;
      word = dut.u_ram.mem[1];
      word[0] = ~word[0];
      dut.u_ram.mem[1] = word;
    end
    rd_en = 1'b1;
    step();
    check("par_valid", 32'(rd_valid), 1);
    check("par_err", 32'(parity_err), 1);
    rd_en = 1'b0;
    step();
    check("par_err_pulse", 32'(parity_err), 0);
`else
    rd_en = 1'b1;
    step();
    check("par_valid", 32'(rd_valid), 1);
    check("par_data", 32'(rd_data), 32'h0F);
    check("par_err_off", 32'(parity_err), 0);
    rd_en = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
